nios_fprint_multi_timer: RTL and testbench

Parametrised multi-channel interval timer and successor of the single-channel Avalon timer. It provides NUM_CH independent down-counters of CNT_W bits, each with a programmable prescaler, a one-shot/continuous mode, snapshot capture and a per-channel interrupt. It sits on the processor's Avalon-MM data bus as a slave and provides the per-core tick and watchdog sources for the fingerprinting system.

---
 rtl/nios_fprint_multi_timer_if.sv | 21 ++
 rtl/nios_fprint_multi_timer.sv | 235 +++++++++++++++++++++++
 tb/tb_nios_fprint_multi_timer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/nios_fprint_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// The master drives address/strobes/data; the slave returns registered readdata.
interface nios_fprint_multi_timer_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_fprint_multi_timer.sv
// NUM_CH independent prescaled down-counters behind an Avalon-MM slave port.
// Optional macro TIMER_CASCADE_EN lets channel n>=1 count channel n-1 timeouts.
module nios_fprint_multi_timer #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int          ADDR_W         = 5,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0007A11F
) (
  input  logic                      clk,
  input  logic                      reset,
  nios_fprint_multi_timer_if.slave  bus,
  output logic [NUM_CH-1:0]         irq_vec,
  output logic                      irq
);

  localparam int CH_W = ADDR_W - 3;
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESC    = 3'd6;

  // Counters are viewed as a zero-extended 64-bit value split into two words,
  // so an upper-word write on a <=32-bit counter falls off the top.
  function automatic logic [31:0] lo_word(input logic [CNT_W-1:0] v);
    logic [63:0] w;
    w = 64'(v);
    return w[31:0];
  endfunction

  function automatic logic [31:0] hi_word(input logic [CNT_W-1:0] v);
    logic [63:0] w;
    w = 64'(v);
    return w[63:32];
  endfunction

  function automatic logic [CNT_W-1:0] set_lo(input logic [CNT_W-1:0] v, input logic [31:0] d);
    logic [63:0] w;
    w = 64'(v);
    w[31:0] = d;
    return w[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] set_hi(input logic [CNT_W-1:0] v, input logic [31:0] d);
    logic [63:0] w;
    w = 64'(v);
    w[63:32] = d;
    return w[CNT_W-1:0];
  endfunction

  logic              wr_s;
  logic [CH_W-1:0]   ch_s;
  logic [2:0]        reg_s;
  logic              ch_ok_s;
  logic [31:0]       wd_s;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] start_s;
  logic [NUM_CH-1:0] stop_s;
  logic [NUM_CH-1:0] zero_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] pulse_s;
  logic [31:0]       word_s;
  logic [31:0]       rd_s;

  logic [NUM_CH-1:0] to_r;
  logic [NUM_CH-1:0] run_r;
  logic [NUM_CH-1:0] ito_r;
  logic [NUM_CH-1:0] cont_r;
  logic [NUM_CH-1:0] reload_r;
`ifdef TIMER_CASCADE_EN
  logic [NUM_CH-1:0] casc_r;
`endif
  logic [15:0]       presc_r  [NUM_CH];
  logic [15:0]       pcnt_r   [NUM_CH];
  logic [CNT_W-1:0]  period_r [NUM_CH];
  logic [CNT_W-1:0]  cnt_r    [NUM_CH];
  logic [CNT_W-1:0]  snap_r   [NUM_CH];
  logic [31:0]       readdata_r;

  assign wr_s    = bus.chipselect & ~bus.write_n;
  assign ch_s    = bus.address[ADDR_W-1:3];
  assign reg_s   = bus.address[2:0];
  assign wd_s    = bus.writedata;
  assign ch_ok_s = (32'(ch_s) < 32'(NUM_CH));

  // Per-channel write selects and the START/STOP command pulses.
  always_comb begin
    sel_s   = {NUM_CH{1'b0}};
    start_s = {NUM_CH{1'b0}};
    stop_s  = {NUM_CH{1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
      sel_s[n]   = wr_s & ch_ok_s & (ch_s == CH_W'(n));
      start_s[n] = sel_s[n] & (reg_s == REG_CONTROL) & wd_s[2];
      stop_s[n]  = sel_s[n] & (reg_s == REG_CONTROL) & wd_s[3];
    end
  end

  // Count enables: prescaler ticks, optionally replaced by the previous channel's timeout.
  always_comb begin
    zero_s  = {NUM_CH{1'b0}};
    tick_s  = {NUM_CH{1'b0}};
    pulse_s = {NUM_CH{1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
      zero_s[n] = (cnt_r[n] == {CNT_W{1'b0}});
      tick_s[n] = run_r[n] & (pcnt_r[n] == 16'd0);
    end
`ifdef TIMER_CASCADE_EN
    pulse_s[0] = tick_s[0] & zero_s[0];
    for (int n = 1; n < NUM_CH; n++) begin
      tick_s[n]  = casc_r[n] ? (run_r[n] & pulse_s[n-1]) : tick_s[n];
      pulse_s[n] = tick_s[n] & zero_s[n];
    end
`else
    pulse_s = tick_s & zero_s;
`endif
  end

  // Channel state: configuration, run control, prescaler, counter, snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_r     <= {NUM_CH{1'b0}};
      run_r    <= {NUM_CH{1'b0}};
      ito_r    <= {NUM_CH{1'b0}};
      cont_r   <= {NUM_CH{1'b0}};
      reload_r <= {NUM_CH{1'b0}};
`ifdef TIMER_CASCADE_EN
      casc_r   <= {NUM_CH{1'b0}};
`endif
      for (int n = 0; n < NUM_CH; n++) begin
        presc_r[n]  <= 16'd0;
        pcnt_r[n]   <= 16'd0;
        period_r[n] <= RST_PERIOD;
        cnt_r[n]    <= RST_PERIOD;
        snap_r[n]   <= {CNT_W{1'b0}};
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        reload_r[n] <= sel_s[n] & ((reg_s == REG_PERIOD_L) |
                                   ((reg_s == REG_PERIOD_H) & (CNT_W > 32)));

        if (sel_s[n] && (reg_s == REG_PERIOD_L)) begin
          period_r[n] <= set_lo(period_r[n], wd_s);
        end else if (sel_s[n] && (reg_s == REG_PERIOD_H)) begin
          period_r[n] <= set_hi(period_r[n], wd_s);
        end

        if (sel_s[n] && (reg_s == REG_PRESC)) begin
          presc_r[n] <= wd_s[15:0];
        end

        if (sel_s[n] && (reg_s == REG_CONTROL)) begin
          ito_r[n]  <= wd_s[0];
          cont_r[n] <= wd_s[1];
`ifdef TIMER_CASCADE_EN
          casc_r[n] <= wd_s[4];
`endif
        end

        // A pending period reload overrides any command; START beats STOP.
        if (reload_r[n]) begin
          run_r[n] <= 1'b0;
        end else if (start_s[n]) begin
          run_r[n] <= 1'b1;
        end else if (stop_s[n]) begin
          run_r[n] <= 1'b0;
        end else if (pulse_s[n] && !cont_r[n]) begin
          run_r[n] <= 1'b0;
        end

        if (reload_r[n]) begin
          cnt_r[n] <= period_r[n];
        end else if (tick_s[n]) begin
          cnt_r[n] <= zero_s[n] ? period_r[n] : (cnt_r[n] - CNT_W'(1'b1));
        end

        if (pulse_s[n]) begin
          to_r[n] <= 1'b1;
        end else if (sel_s[n] && (reg_s == REG_STATUS)) begin
          to_r[n] <= 1'b0;
        end

        if (sel_s[n] && ((reg_s == REG_SNAP_L) || (reg_s == REG_SNAP_H))) begin
          snap_r[n] <= cnt_r[n];
        end

        if (start_s[n]) begin
          pcnt_r[n] <= presc_r[n];
        end else if (run_r[n]) begin
          pcnt_r[n] <= (pcnt_r[n] == 16'd0) ? presc_r[n] : (pcnt_r[n] - 16'd1);
        end
      end
    end
  end

  // Register read mux; unselected and out-of-range channels contribute zero.
  always_comb begin
    rd_s   = 32'd0;
    word_s = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      case (reg_s)
        REG_STATUS:   word_s = {30'd0, run_r[n], to_r[n]};
`ifdef TIMER_CASCADE_EN
        REG_CONTROL:  word_s = {27'd0, casc_r[n], 2'b00, cont_r[n], ito_r[n]};
`else
        REG_CONTROL:  word_s = {27'd0, 1'b0, 2'b00, cont_r[n], ito_r[n]};
`endif
        REG_PERIOD_L: word_s = lo_word(period_r[n]);
        REG_PERIOD_H: word_s = hi_word(period_r[n]);
        REG_SNAP_L:   word_s = lo_word(snap_r[n]);
        REG_SNAP_H:   word_s = hi_word(snap_r[n]);
        REG_PRESC:    word_s = {16'd0, presc_r[n]};
        default:      word_s = 32'd0;
      endcase
      rd_s = rd_s | ((ch_ok_s && (ch_s == CH_W'(n))) ? word_s : 32'd0);
    end
  end

  // One-cycle read latency, no wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= 32'd0;
    end else begin
      readdata_r <= rd_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign irq_vec      = to_r & ito_r;
  assign irq          = |irq_vec;

endmodule

// File: tb/tb_nios_fprint_multi_timer.sv
// Self-checking bench: directed scenarios plus randomized channel programming
// checked against a closed-form timing model ((P+1)*(D+1) cycles per timeout).
module tb_nios_fprint_multi_timer;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int          ADDR_W = 6;
  localparam logic [31:0] DEF_P  = 32'h0007A11F;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  nios_fprint_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

  nios_fprint_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .DEFAULT_PERIOD(DEF_P)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq_vec(irq_vec), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int last_edge = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write captured at the posedge between two negedges; last_edge = that edge index.
  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    @(negedge clk);
    bus.address    = ADDR_W'((ch << 3) | rg);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    last_edge      = cyc;
  endtask

  // Returned data reflects the register state after edge (last_edge - 1).
  task automatic rd(input int ch, input int rg, output logic [31:0] d);
    @(negedge clk);
    bus.address    = ADDR_W'((ch << 3) | rg);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d              = bus.readdata;
    bus.chipselect = 1'b0;
    last_edge      = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Channel state m edges after the START edge, with counter preloaded to p.
  function automatic void model(input int m, input int p, input int d, input bit cont,
                                output int cnt, output bit to, output bit run);
    int j;
    j = m / (d + 1);
    if (cont) begin
      run = 1'b1;
      to  = (j >= p + 1);
      cnt = p - (j % (p + 1));
    end else if (j >= p + 1) begin
      run = 1'b0;
      to  = 1'b1;
      cnt = p;
    end else begin
      run = 1'b1;
      to  = 1'b0;
      cnt = p - j;
    end
  endfunction

  initial begin
    logic [31:0] rdv;
    int s, w, c, ch, p, d, k, cnt_e;
    bit cont, to_e, run_e;

    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst_readdata", bus.readdata, 32'd0);
    check_val("rst_irq", irq, 1'b0);
    check_val("rst_irq_vec", irq_vec, 4'd0);
    reset = 1'b0;

    rd(0, 2, rdv); check_val("rst_period_l", rdv, DEF_P);
    rd(0, 3, rdv); check_val("rst_period_h", rdv, 32'd0);
    rd(0, 0, rdv); check_val("rst_status", rdv, 32'd0);
    rd(2, 1, rdv); check_val("rst_control", rdv, 32'd0);
    rd(3, 6, rdv); check_val("rst_presc", rdv, 32'd0);
    rd(1, 4, rdv); check_val("rst_snap", rdv, 32'd0);
    rd(5, 2, rdv); check_val("bad_ch_read", rdv, 32'd0);
    rd(1, 7, rdv); check_val("reserved_read", rdv, 32'd0);

    // ch1 continuous, period 9, no prescale
    wr(1, 2, 32'd9); wr(1, 6, 32'd0); wr(1, 1, 32'h7); s = last_edge;
    wait_until(s + 9);  check_val("ch1_irq_pre", irq_vec[1], 1'b0);
    wait_until(s + 10); check_val("ch1_irq_first", irq_vec[1], 1'b1);
    check_val("ch1_irq_or", irq, 1'b1);
    wr(1, 0, 32'd0);    check_val("ch1_irq_clr", irq_vec[1], 1'b0);
    wait_until(s + 19); check_val("ch1_irq_gap", irq_vec[1], 1'b0);
    wait_until(s + 20); check_val("ch1_irq_second", irq_vec[1], 1'b1);

    // ch2 one-shot, period 3, prescale 4
    wr(2, 2, 32'd3); wr(2, 6, 32'd4); wr(2, 1, 32'h5); s = last_edge;
    wait_until(s + 19); check_val("ch2_irq_pre", irq_vec[2], 1'b0);
    wait_until(s + 20); check_val("ch2_irq_once", irq_vec[2], 1'b1);
    wait_until(s + 45);
    rd(2, 0, rdv);      check_val("ch2_status_done", rdv, 32'h1);
    wr(2, 0, 32'd0);
    repeat (30) @(negedge clk);
    check_val("ch2_no_more_irq", irq_vec[2], 1'b0);
    rd(2, 2, rdv);      check_val("ch2_period_kept", rdv, 32'd3);

    // ch0 period 100: snapshot after 37 ticks, then period write stops it
    wr(0, 2, 32'd100); wr(0, 6, 32'd0); wr(0, 1, 32'h6); s = last_edge;
    wait_until(s + 36);
    wr(0, 4, 32'd0);
    rd(0, 4, rdv);      check_val("ch0_snap37", rdv, 32'd63);
    wr(0, 2, 32'd50);
    rd(0, 0, rdv);      check_val("ch0_reload_run", rdv, 32'd0);
    wr(0, 5, 32'd0);
    rd(0, 4, rdv);      check_val("ch0_reload_cnt", rdv, 32'd50);
    rd(0, 5, rdv);      check_val("ch0_snap_h", rdv, 32'd0);

    // ch3: status clear colliding with a timeout, then START+STOP together
    wr(3, 2, 32'd5); wr(3, 6, 32'd0); wr(3, 1, 32'h7); s = last_edge;
    wait_until(s + 4);
    wr(3, 0, 32'd0);
    check_val("ch3_clr_edge", last_edge, s + 6);
    check_val("ch3_to_wins_irq", irq_vec[3], 1'b1);
    rd(3, 0, rdv);      check_val("ch3_to_wins_status", rdv, 32'h3);
    wr(3, 1, 32'h8);
    rd(3, 0, rdv);      check_val("ch3_stop_run", rdv[1], 1'b0);
    wr(3, 1, 32'h0F);
    rd(3, 0, rdv);      check_val("ch3_start_stop_run", rdv[1], 1'b1);
    rd(3, 1, rdv);      check_val("ch3_ctrl_pulses_rd0", rdv, 32'h3);
    wr(3, 1, 32'h13);
    rd(3, 1, rdv);
`ifdef TIMER_CASCADE_EN
    check_val("ch3_casc_bit", rdv, 32'h13);
`else
    check_val("ch3_casc_bit", rdv, 32'h03);
`endif
    wr(5, 2, 32'd7);
    rd(1, 2, rdv);      check_val("bad_ch_write", rdv, 32'd9);

    // randomized programming checked against the closed-form model
    for (int it = 0; it < 24; it++) begin
      ch   = $urandom_range(0, NUM_CH - 1);
      p    = $urandom_range(0, 12);
      d    = $urandom_range(0, 3);
      cont = 1'($urandom_range(0, 1));
      k    = $urandom_range(0, 70);
      wr(ch, 2, 32'(p));
      wr(ch, 6, 32'(d));
      wr(ch, 0, 32'd0);
      wr(ch, 1, 32'h5 | (32'(cont) << 1));
      s = last_edge;
      repeat (k) @(negedge clk);
      wr(ch, 4, 32'd0);
      w = last_edge;
      model(w - s, p, d, cont, cnt_e, to_e, run_e);
      check_val($sformatf("rnd%0d_irq", it), irq_vec[ch], to_e);
      model(w - 1 - s, p, d, cont, cnt_e, to_e, run_e);
      rd(ch, 4, rdv);
      check_val($sformatf("rnd%0d_snap", it), rdv, 32'(cnt_e));
      rd(ch, 0, rdv);
      c = last_edge;
      model(c - 1 - s, p, d, cont, cnt_e, to_e, run_e);
      check_val($sformatf("rnd%0d_status", it), rdv, {30'd0, run_e, to_e});
    end

    // reset while counting clears everything on the next edge
    wr(1, 2, 32'd2); wr(1, 6, 32'd0); wr(1, 1, 32'h7);
    repeat (10) @(negedge clk);
    check_val("pre_rst_irq", irq, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_irq", irq, 1'b0);
    check_val("mid_rst_irq_vec", irq_vec, 4'd0);
    check_val("mid_rst_readdata", bus.readdata, 32'd0);
    reset = 1'b0;
    rd(1, 2, rdv);      check_val("post_rst_period", rdv, DEF_P);
    rd(1, 0, rdv);      check_val("post_rst_status", rdv, 32'd0);
    repeat (20) @(negedge clk);
    check_val("post_rst_irq", irq, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
